// File: rtl/debounce_multi.sv
// Multi-channel debouncer. Each channel has a 2-flop synchroniser, a tick-qualified
// stability counter, a registered debounced level and one-cycle rise/fall pulses.
module debounce_multi #(
    parameter int unsigned         CHANNELS     = 4,
    parameter int unsigned         CNT_WIDTH    = 16,
    parameter int unsigned         STABLE_COUNT = 50000,
    parameter logic [CHANNELS-1:0] IDLE_LEVEL   = {CHANNELS{1'b0}}
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                tick,
    input  logic [CHANNELS-1:0] din,
    output logic [CHANNELS-1:0] dout,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] busy
);

    // STABLE_COUNT may equal 2^CNT_WIDTH, so only the terminal value has to fit.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_COUNT - 1);

    logic [CHANNELS-1:0]  sync1_q;
    logic [CHANNELS-1:0]  sync2_q;
    logic [CHANNELS-1:0]  dout_q;
    logic [CHANNELS-1:0]  dout_d;
    logic [CHANNELS-1:0]  rise_q;
    logic [CHANNELS-1:0]  fall_q;
    logic [CNT_WIDTH-1:0] cnt_q [CHANNELS];
    logic [CNT_WIDTH-1:0] cnt_d [CHANNELS];

    // Any match restarts the window; a full window of qualifying ticks commits the new level.
    always_comb begin
        dout_d = dout_q;
        cnt_d  = cnt_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sync2_q[i] == dout_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick) begin
                if (cnt_q[i] == CNT_LAST) begin
                    dout_d[i] = sync2_q[i];
                    cnt_d[i]  = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= IDLE_LEVEL;
            sync2_q <= IDLE_LEVEL;
            dout_q  <= IDLE_LEVEL;
            rise_q  <= '0;
            fall_q  <= '0;
            cnt_q   <= '{default: '0};
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            dout_q  <= dout_d;
            rise_q  <= dout_d & ~dout_q;
            fall_q  <= ~dout_d & dout_q;
            cnt_q   <= cnt_d;
        end
    end

    assign dout = dout_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = sync2_q ^ dout_q;

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi: stimulus queues expected pulses (cycle, rise, fall,
// dout); a negedge monitor pops and compares whenever any rise/fall pulse is present.
module tb_debounce_multi;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b1;
    logic       tick    = 1'b1;
    logic [1:0] din     = 2'b00;
    logic [1:0] dout;
    logic [1:0] rise;
    logic [1:0] fall;
    logic [1:0] busy;

    int cyc    = 0;
    int n_vec  = 0;
    int n_miss = 0;
    bit gate_en = 1'b0;

    typedef struct {
        int         cyc;
        logic [1:0] rise;
        logic [1:0] fall;
        logic [1:0] dout;
    } exp_t;

    exp_t exp_q[$];

    debounce_multi #(
        .CHANNELS     (2),
        .CNT_WIDTH    (3),
        .STABLE_COUNT (4),
        .IDLE_LEVEL   (2'b00)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick),
        .din     (din),
        .dout    (dout),
        .rise    (rise),
        .fall    (fall),
        .busy    (busy)
    );

    always #160 clk = ~clk;

    always @(posedge clk) cyc++;

    // Gated mode: tick is high for edge e exactly when e % 3 == 0.
    always @(negedge clk) tick = gate_en ? ((cyc % 3) == 2) : 1'b1;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset_n && ((rise | fall) != 2'b00)) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL pulse_unexpected: cyc %0d got rise %b fall %b, required no pulse",
                         cyc, rise, fall);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.rise !== rise || e.fall !== fall || e.dout !== dout) begin
                    n_miss++;
                    $display({"FAIL pulse: got cyc %0d rise %b fall %b dout %b, ",
                              "required cyc %0d rise %b fall %b dout %b"},
                             cyc, rise, fall, dout, e.cyc, e.rise, e.fall, e.dout);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: cyc %0d got %b, required %b", name, cyc, act, req);
        end
    endtask

    task automatic expect_pulse(input int c, input logic [1:0] r, input logic [1:0] f,
                                input logic [1:0] d);
        exp_t e;
        e.cyc  = c;
        e.rise = r;
        e.fall = f;
        e.dout = d;
        exp_q.push_back(e);
    endtask

    // n-th tick-high edge at or after edge 'start' in gated mode.
    function automatic int nth_tick(input int start, input int n);
        int k = 0;
        for (int e = start; e < start + 3 * n + 3; e++) begin
            if (e % 3 == 0) begin
                k++;
                if (k == n) return e;
            end
        end
        return -1;
    endfunction

    initial begin
        int c;
        int c2;

        // Reset values, asserted mid-clock before any edge
        #10 reset_n = 1'b0;
        #1;
        check("reset_dout", dout, 2'b00);
        check("reset_rise", rise, 2'b00);
        check("reset_fall", fall, 2'b00);
        check("reset_busy", busy, 2'b00);
        step(2);
        reset_n = 1'b1;
        step(2);

        // Clean press on channel 0
        din[0] = 1'b1;
        c = cyc;
        expect_pulse(c + 6, 2'b01, 2'b00, 2'b01);
        step(1);
        check("press_busy_early", busy, 2'b00);
        step(1);
        check("press_busy", busy, 2'b01);
        step(3);
        check("press_dout_before", dout, 2'b00);
        step(1);
        check("press_dout", dout, 2'b01);
        check("press_busy_done", busy, 2'b00);
        step(1);
        check("press_rise_cleared", rise, 2'b00);

        // Release channel 0 so the bounce starts from a low level
        din = 2'b00;
        c = cyc;
        expect_pulse(c + 6, 2'b00, 2'b01, 2'b00);
        step(8);

        // Bounce: toggle every clock, end on 1 and hold
        for (int i = 0; i < 9; i++) begin
            din[0] = (i % 2 == 0);
            c = cyc;
            step(1);
        end
        expect_pulse(c + 6, 2'b01, 2'b00, 2'b01);
        step(4);
        check("bounce_dout_low", dout, 2'b00);
        step(3);
        check("bounce_dout_high", dout, 2'b01);

        // Bring channel 1 up, then release both together
        din = 2'b11;
        c = cyc;
        expect_pulse(c + 6, 2'b10, 2'b00, 2'b11);
        step(8);
        check("both_high", dout, 2'b11);
        din = 2'b00;
        c = cyc;
        expect_pulse(c + 6, 2'b00, 2'b11, 2'b00);
        step(8);
        check("both_low", dout, 2'b00);

        // Tick gating: clean commit, then a glitch that restarts the count
        gate_en = 1'b1;
        step(3);
        din[1] = 1'b1;
        c = cyc;
        expect_pulse(nth_tick(c + 3, 4), 2'b10, 2'b00, 2'b10);
        step(20);
        check("gated_dout", dout, 2'b10);
        din[1] = 1'b0;
        step(5);
        din[1] = 1'b1;
        c2 = cyc;
        step(1);
        din[1] = 1'b0;
        expect_pulse(nth_tick(c2 + 4, 4), 2'b00, 2'b10, 2'b00);
        step(20);
        check("glitch_dout", dout, 2'b00);
        gate_en = 1'b0;
        step(3);

        // Reset mid-count discards the pending change
        din[0] = 1'b1;
        step(5);
        check("midcount_busy", busy, 2'b01);
        #20 reset_n = 1'b0;
        #1;
        check("midreset_dout", dout, 2'b00);
        check("midreset_busy", busy, 2'b00);
        check("midreset_rise", rise, 2'b00);
        step(2);
        reset_n = 1'b1;
        c = cyc;
        expect_pulse(c + 6, 2'b01, 2'b00, 2'b01);
        step(5);
        check("postreset_dout_low", dout, 2'b00);
        step(5);
        check("postreset_dout", dout, 2'b01);

        // Every queued pulse must have been seen
        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL pulses_missing: got %0d outstanding, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
